// File: rtl/char_board_mem.sv
// Board field store (256 x {revealed, index}) with a scaled 10x10 digit font.
// Returns one glyph line per field one clock after char_x/char_y/char_line are presented.
module char_board_mem #(
    parameter int GLYPH_W = 50,
    parameter int SCALE   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         char_x,
    input  logic [3:0]         char_y,
    input  logic [5:0]         char_line,
    output logic [GLYPH_W-1:0] char_pixels,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [3:0]         wr_x,
    input  logic [3:0]         wr_y,
    input  logic [3:0]         wr_index,
    input  logic               wr_reveal,
    input  logic               clear_start,
    output logic               busy
);

    // state    | meaning
    // ST_CLEAR | sweeping one entry per cycle to zero, writes refused
    // ST_IDLE  | accepting writes and clear_start
    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    // Digits 1..8, rows 0..9 top to bottom, bit 9 is the leftmost column.
    localparam logic [0:7][0:9][9:0] FONT = {
        {10'h030, 10'h070, 10'h0F0, 10'h030, 10'h030, 10'h030, 10'h030, 10'h030, 10'h030, 10'h0FC},
        {10'h1FE, 10'h303, 10'h003, 10'h006, 10'h00C, 10'h018, 10'h060, 10'h180, 10'h300, 10'h3FF},
        {10'h3FE, 10'h003, 10'h003, 10'h003, 10'h0FE, 10'h003, 10'h003, 10'h003, 10'h003, 10'h3FE},
        {10'h306, 10'h306, 10'h306, 10'h306, 10'h3FF, 10'h006, 10'h006, 10'h006, 10'h006, 10'h006},
        {10'h3FF, 10'h300, 10'h300, 10'h300, 10'h3FE, 10'h003, 10'h003, 10'h003, 10'h303, 10'h1FE},
        {10'h1FE, 10'h300, 10'h300, 10'h300, 10'h3FE, 10'h303, 10'h303, 10'h303, 10'h303, 10'h1FE},
        {10'h3FF, 10'h003, 10'h006, 10'h00C, 10'h018, 10'h030, 10'h030, 10'h030, 10'h030, 10'h030},
        {10'h1FE, 10'h303, 10'h303, 10'h303, 10'h1FE, 10'h303, 10'h303, 10'h303, 10'h303, 10'h1FE}
    };

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [4:0]         mem [256];
    logic               mem_we;
    logic [7:0]         mem_waddr;
    logic [4:0]         mem_wdata;
    logic [4:0]         rd_entry;
    logic [3:0]         rd_row;
    logic [9:0]         row_bits;
    logic [GLYPH_W-1:0] pix_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = {wr_y, wr_x};
        mem_wdata = {wr_reveal, wr_index};
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = 5'd0;
                cnt_d     = cnt_q + 8'd1;
                if (cnt_q == 8'd255) state_d = ST_IDLE;
            end
            default: begin
                mem_we = wr_valid;
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = 8'd0;
                end
            end
        endcase
    end

    assign wr_ready = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_CLEAR);

    // Asynchronous array read; registering the pixels gives the one-cycle latency
    // and makes a same-address write visible only on the following read.
    assign rd_entry = mem[{char_y, char_x}];

    always_comb begin
        pix_d    = '0;
        rd_row   = '0;
        row_bits = '0;
        if (rd_entry[4] && rd_entry[3:0] != 4'd0 && rd_entry[3:0] < 4'd9 &&
            int'(char_line) < 10 * SCALE) begin
            rd_row   = 4'(int'(char_line) / SCALE);
            row_bits = FONT[3'(rd_entry[3:0] - 4'd1)][rd_row];
            for (int i = 0; i < GLYPH_W; i++) begin
                pix_d[i] = row_bits[i / SCALE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= 8'd0;
            char_pixels <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            char_pixels <= pix_d;
        end
    end

    // The array has no reset; the sweep that follows reset zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_char_board_mem.sv
// Randomised and directed checks of char_board_mem against an array-based board model
// and an independent copy of the digit font.
module tb_char_board_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  char_x, char_y;
    logic [5:0]  char_line;
    logic [49:0] char_pixels;
    logic        wr_valid, wr_ready;
    logic [3:0]  wr_x, wr_y, wr_index;
    logic        wr_reveal, clear_start, busy;

    int nvec = 0;
    int nerr = 0;

    logic [4:0] model [256];

    localparam logic [0:7][0:9][9:0] FONT_TB = {
        {10'h030, 10'h070, 10'h0F0, 10'h030, 10'h030, 10'h030, 10'h030, 10'h030, 10'h030, 10'h0FC},
        {10'h1FE, 10'h303, 10'h003, 10'h006, 10'h00C, 10'h018, 10'h060, 10'h180, 10'h300, 10'h3FF},
        {10'h3FE, 10'h003, 10'h003, 10'h003, 10'h0FE, 10'h003, 10'h003, 10'h003, 10'h003, 10'h3FE},
        {10'h306, 10'h306, 10'h306, 10'h306, 10'h3FF, 10'h006, 10'h006, 10'h006, 10'h006, 10'h006},
        {10'h3FF, 10'h300, 10'h300, 10'h300, 10'h3FE, 10'h003, 10'h003, 10'h003, 10'h303, 10'h1FE},
        {10'h1FE, 10'h300, 10'h300, 10'h300, 10'h3FE, 10'h303, 10'h303, 10'h303, 10'h303, 10'h1FE},
        {10'h3FF, 10'h003, 10'h006, 10'h00C, 10'h018, 10'h030, 10'h030, 10'h030, 10'h030, 10'h030},
        {10'h1FE, 10'h303, 10'h303, 10'h303, 10'h1FE, 10'h303, 10'h303, 10'h303, 10'h303, 10'h1FE}
    };

    char_board_mem #(.GLYPH_W(50), .SCALE(5)) dut (
        .clk(clk), .rst(rst),
        .char_x(char_x), .char_y(char_y), .char_line(char_line),
        .char_pixels(char_pixels),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_index(wr_index), .wr_reveal(wr_reveal),
        .clear_start(clear_start), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [49:0] exp_pix(input logic [4:0] e, input int line);
        logic [49:0] r;
        logic [9:0]  bits;
        int          idx;
        r   = '0;
        idx = int'(e[3:0]);
        if (!e[4] || idx == 0 || idx >= 9 || line >= 50) return r;
        bits = FONT_TB[idx - 1][line / 5];
        for (int p = 0; p < 50; p++) r[p] = bits[p / 5];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_model();
        for (int a = 0; a < 256; a++) model[a] = 5'd0;
    endtask

    // One idle cycle: drive a write/clear/read, check the registered pixels.
    task automatic cyc(input logic wv, input logic [3:0] wx, input logic [3:0] wy,
                       input logic [3:0] wi, input logic wrv, input logic cs,
                       input logic [3:0] cx, input logic [3:0] cy, input logic [5:0] cl,
                       input string tag);
        logic [49:0] expv;
        wr_valid = wv; wr_x = wx; wr_y = wy; wr_index = wi; wr_reveal = wrv;
        clear_start = cs; char_x = cx; char_y = cy; char_line = cl;
        expv = exp_pix(model[{cy, cx}], int'(cl));
        #1;
        chk("wr_ready_idle", 64'(wr_ready), 64'd1);
        tick();
        chk(tag, 64'(char_pixels), 64'(expv));
        if (wv) model[{wy, wx}] = {wrv, wi};
    endtask

    task automatic count_busy(input int start, output int n);
        n = start;
        while (busy === 1'b1 && n < 400) begin
            chk("wr_ready_clear", 64'(wr_ready), 64'd0);
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; wr_valid = 0; wr_x = 0; wr_y = 0; wr_index = 0; wr_reveal = 0;
        clear_start = 0; char_x = 0; char_y = 0; char_line = 0;
        tick(); tick(); tick();
        chk("rst_pixels", 64'(char_pixels), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_ready", 64'(wr_ready), 64'd0);
        rst = 1'b0;
        count_busy(0, n);
        chk("post_reset_busy_len", 64'(n), 64'd256);
        zero_model();
        for (int k = 0; k < 16; k++)
            cyc(0, 0, 0, 0, 0, 0, 4'($urandom), 4'($urandom), 6'($urandom), "swept_read");

        // Reveal digit 1 and scan all lines of the field.
        cyc(1, 3, 2, 1, 1, 0, 0, 0, 0, "wr_d1");
        for (int l = 0; l < 64; l++) cyc(0, 0, 0, 0, 0, 0, 3, 2, 6'(l), "glyph1_line");

        // Fields that must stay blank.
        cyc(1, 4, 4, 5, 0, 0, 0, 0, 0, "wr_hidden");
        cyc(1, 6, 4, 0, 1, 0, 0, 0, 0, "wr_zero");
        cyc(1, 7, 4, 12, 1, 0, 0, 0, 0, "wr_big");
        for (int l = 0; l < 50; l += 7) begin
            cyc(0, 0, 0, 0, 0, 0, 4, 4, 6'(l), "blank_hidden");
            cyc(0, 0, 0, 0, 0, 0, 6, 4, 6'(l), "blank_zero");
            cyc(0, 0, 0, 0, 0, 0, 7, 4, 6'(l), "blank_big");
        end

        // Read-before-write on the same address.
        cyc(1, 5, 5, 3, 1, 0, 0, 0, 0, "wr_d3");
        cyc(1, 5, 5, 7, 1, 0, 5, 5, 12, "collide_old");
        cyc(0, 0, 0, 0, 0, 0, 5, 5, 12, "collide_new");

        // Randomised traffic on a small corner so reads and writes collide often.
        for (int k = 0; k < 400; k++)
            cyc(1'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                4'($urandom), 1'($urandom), 0,
                4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 6'($urandom), "rand");

        // Write accepted together with clear_start, then held during the sweep.
        cyc(1, 0, 0, 4, 1, 1, 0, 0, 0, "hs_old");
        clear_start = 0;
        tick();
        chk("hs_landed", 64'(char_pixels), 64'(exp_pix(5'h14, 0)));
        n = 1;
        while (busy === 1'b1 && n < 400) begin
            clear_start = (n == 50);
            chk("wr_ready_clear", 64'(wr_ready), 64'd0);
            tick();
            n++;
        end
        clear_start = 0;
        chk("hs_busy_len", 64'(n), 64'd256);
        zero_model();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "hs_cleared");
        cyc(0, 0, 0, 0, 0, 0, 5, 5, 12, "hs_cleared_55");

        // Reset in the middle of a sweep.
        cyc(1, 15, 15, 8, 1, 0, 0, 0, 0, "wr_d8");
        cyc(0, 0, 0, 0, 0, 1, 15, 15, 20, "mid_start");
        for (int k = 0; k < 100; k++) tick();
        rst = 1'b1;
        tick(); tick();
        chk("mid_rst_busy", 64'(busy), 64'd1);
        chk("mid_rst_pixels", 64'(char_pixels), 64'd0);
        rst = 1'b0;
        count_busy(0, n);
        chk("mid_rst_busy_len", 64'(n), 64'd256);
        zero_model();
        cyc(0, 0, 0, 0, 0, 0, 15, 15, 20, "mid_cleared_ff");
        for (int k = 0; k < 16; k++)
            cyc(0, 0, 0, 0, 0, 0, 4'($urandom), 4'($urandom), 6'($urandom), "mid_cleared");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
